// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz step counter: FSM state encoding and
// the bit positions inside the {timeout, overflow, zero_input} flag vector.
package collatz_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned NumFlags     = 3;
   localparam int unsigned FlagZero     = 0;
   localparam int unsigned FlagOverflow = 1;
   localparam int unsigned FlagTimeout  = 2;

endpackage

// File: rtl/collatz_step.sv
// One Collatz iteration: halve even values, 3v+1 for odd values.
// The odd product is formed two bits wider than the value so that any
// result that no longer fits in WIDTH bits is reported as overflow.
module collatz_step #(
   parameter int unsigned WIDTH = 27
) (
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] next_o,
   output logic             overflow_o
);

   logic [WIDTH+1:0] triple_plus_one;

   // Next value and overflow detection for the current value.
   always_comb begin
      triple_plus_one = {2'b00, value_i} + {1'b0, value_i, 1'b0} +
                        {{(WIDTH+1){1'b0}}, 1'b1};
      next_o          = {1'b0, value_i[WIDTH-1:1]};
      overflow_o      = 1'b0;
      if (value_i[0]) begin
         next_o     = triple_plus_one[WIDTH-1:0];
         overflow_o = |triple_plus_one[WIDTH+1:WIDTH];
      end
   end

endmodule

// File: rtl/collatz_steps.sv
// Collatz step counter with valid/ready handshakes on input and result.
// Accepts a start value in IDLE, iterates one step per cycle in RUN and
// presents the step count plus {timeout, overflow, zero_input} flags in DONE.
// Optional feature: define COLLATZ_PEAK_EN to add out1, the largest value
// reached during the run (including the start value).
module collatz_steps
   import collatz_pkg::*;
#(
   parameter int unsigned WIDTH     = 27,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in0,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] out0,
   output logic [NumFlags-1:0]  out_flags
`ifdef COLLATZ_PEAK_EN
   ,
   output logic [WIDTH-1:0]     out1
`endif
);

   localparam logic [WIDTH-1:0]     ValOne = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_e                state_q, state_d;
   logic [WIDTH-1:0]      value_q, value_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [CNT_WIDTH-1:0]  out0_q, out0_d;
   logic [NumFlags-1:0]   flags_q, flags_d;

   logic [WIDTH-1:0]      step_next;
   logic                  step_ovf;
   logic                  accept;
   logic                  is_one;
   logic                  cnt_full;
   logic                  advance;
   logic                  run_finish;

   collatz_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .value_i   (value_q),
      .next_o    (step_next),
      .overflow_o(step_ovf)
   );

   // Handshake outputs decode straight from the state register.
   always_comb begin
      in_ready   = (state_q == StIdle);
      out_valid  = (state_q == StDone);
      accept     = in_ready && in_valid;
      is_one     = (value_q == ValOne);
      cnt_full   = (count_q == {CNT_WIDTH{1'b1}});
      advance    = (state_q == StRun) && !is_one && !cnt_full && !step_ovf;
      run_finish = (state_q == StRun) && !advance;
   end

   // FSM next state, working registers and result capture.
   always_comb begin
      state_d = state_q;
      value_d = value_q;
      count_d = count_q;
      out0_d  = out0_q;
      flags_d = flags_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               value_d = in0;
               count_d = '0;
               if (in0 == '0) begin
                  // Zero never reaches 1: report immediately without running.
                  state_d           = StDone;
                  out0_d            = '0;
                  flags_d           = '0;
                  flags_d[FlagZero] = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         StRun: begin
            if (advance) begin
               value_d = step_next;
               count_d = count_q + CntOne;
            end else begin
               // Priority: reached 1, then counter exhausted, then overflow.
               state_d = StDone;
               out0_d  = count_q;
               flags_d = '0;
               if (!is_one) begin
                  if (cnt_full) begin
                     flags_d[FlagTimeout] = 1'b1;
                  end else begin
                     flags_d[FlagOverflow] = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and result registers; reset aborts any computation in flight.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= StIdle;
         value_q <= '0;
         count_q <= '0;
         out0_q  <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         count_q <= count_d;
         out0_q  <= out0_d;
         flags_q <= flags_d;
      end
   end

   assign out0      = out0_q;
   assign out_flags = flags_q;

`ifdef COLLATZ_PEAK_EN
   logic [WIDTH-1:0] peak_q, peak_d;
   logic [WIDTH-1:0] out1_q, out1_d;

   // Running maximum; captured into out1 alongside out0 on entering DONE.
   always_comb begin
      peak_d = peak_q;
      out1_d = out1_q;
      if (accept) begin
         peak_d = in0;
         if (in0 == '0) begin
            out1_d = '0;
         end
      end else if (advance && (step_next > peak_q)) begin
         peak_d = step_next;
      end
      if (run_finish) begin
         out1_d = peak_q;
      end
   end

   // Peak and captured-peak registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         peak_q <= '0;
         out1_q <= '0;
      end else begin
         peak_q <= peak_d;
         out1_q <= out1_d;
      end
   end

   assign out1 = out1_q;
`else
   // Without the peak feature run_finish has no consumer.
   logic unused_run_finish;
   assign unused_run_finish = run_finish;
`endif

endmodule

// File: tb/tb_collatz_steps.sv
// Self-checking bench for collatz_steps: three instances (defaults, WIDTH=8,
// CNT_WIDTH=4) checked against an arithmetic Collatz reference model.
module tb_collatz_steps;
   import collatz_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        nrst;
   logic [2:0]  iv;
   logic [2:0]  orr;
   wire  [2:0]  ir;
   wire  [2:0]  ov;
   logic [26:0] in0_v;

   logic [15:0] o0_0, o0_1;
   logic [3:0]  o0_2;
   logic [2:0]  of_0, of_1, of_2;
`ifdef COLLATZ_PEAK_EN
   logic [26:0] o1_0, o1_2;
   logic [7:0]  o1_1;
`endif

   int checks = 0;
   int errors = 0;

   collatz_steps dut0 (
      .clk(clk), .nrst(nrst), .in_valid(iv[0]), .in_ready(ir[0]), .in0(in0_v),
      .out_valid(ov[0]), .out_ready(orr[0]), .out0(o0_0), .out_flags(of_0)
`ifdef COLLATZ_PEAK_EN
      , .out1(o1_0)
`endif
   );

   collatz_steps #(.WIDTH(8)) dut1 (
      .clk(clk), .nrst(nrst), .in_valid(iv[1]), .in_ready(ir[1]), .in0(in0_v[7:0]),
      .out_valid(ov[1]), .out_ready(orr[1]), .out0(o0_1), .out_flags(of_1)
`ifdef COLLATZ_PEAK_EN
      , .out1(o1_1)
`endif
   );

   collatz_steps #(.CNT_WIDTH(4)) dut2 (
      .clk(clk), .nrst(nrst), .in_valid(iv[2]), .in_ready(ir[2]), .in0(in0_v),
      .out_valid(ov[2]), .out_ready(orr[2]), .out0(o0_2), .out_flags(of_2)
`ifdef COLLATZ_PEAK_EN
      , .out1(o1_2)
`endif
   );

   function automatic logic [63:0] g_o0(input int k);
      case (k)
         0:       return {48'd0, o0_0};
         1:       return {48'd0, o0_1};
         default: return {60'd0, o0_2};
      endcase
   endfunction

   function automatic logic [63:0] g_fl(input int k);
      case (k)
         0:       return {61'd0, of_0};
         1:       return {61'd0, of_1};
         default: return {61'd0, of_2};
      endcase
   endfunction

`ifdef COLLATZ_PEAK_EN
   function automatic logic [63:0] g_o1(input int k);
      case (k)
         0:       return {37'd0, o1_0};
         1:       return {56'd0, o1_1};
         default: return {37'd0, o1_2};
      endcase
   endfunction
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: walk the Collatz sequence with plain integer arithmetic.
   task automatic model(input longint v0, input int w, input int cw,
                        output longint steps, output logic [2:0] fl,
                        output longint peak, output int lat);
      longint v;
      longint s;
      longint limit;
      longint cmax;
      v     = v0;
      s     = 0;
      fl    = 3'b000;
      peak  = v0;
      limit = longint'(1) << w;
      cmax  = (longint'(1) << cw) - 1;
      if (v0 == 0) begin
         fl[FlagZero] = 1'b1;
         steps = 0;
         peak  = 0;
         lat   = 0;
         return;
      end
      while (v != 1) begin
         if (s == cmax) begin
            fl[FlagTimeout] = 1'b1;
            break;
         end
         if (v % 2 == 0) begin
            v = v / 2;
         end else begin
            if (3 * v + 1 >= limit) begin
               fl[FlagOverflow] = 1'b1;
               break;
            end
            v = 3 * v + 1;
         end
         s++;
         if (v > peak) peak = v;
      end
      steps = s;
      lat   = int'(s) + 1;
   endtask

   // One full transaction on instance k, with hold cycles of back-pressure.
   task automatic run(input int k, input longint v, input int w, input int cw,
                      input int hold, input string tag,
                      output logic [63:0] got_o0, output logic [63:0] got_fl,
                      output int got_lat);
      longint     e_steps, e_peak;
      logic [2:0] e_fl;
      int         e_lat;
      int         lat;
      logic [63:0] held;
      model(v, w, cw, e_steps, e_fl, e_peak, e_lat);
      @(posedge clk); #1;
      check({tag, ".ready"}, {63'd0, ir[k]}, 64'd1);
      in0_v = v[26:0];
      iv[k] = 1'b1;
      @(posedge clk); #1;
      // Keep in_valid high with junk while busy; it must be ignored.
      in0_v = 27'($urandom);
      lat = 0;
      while (!ov[k] && lat < 5000) begin
         @(posedge clk); #1;
         lat++;
         iv[k] = (lat < 3);
         in0_v = 27'($urandom);
      end
      iv[k] = 1'b0;
      check({tag, ".latency"}, 64'(lat), 64'(e_lat));
      check({tag, ".out0"}, g_o0(k), 64'(e_steps));
      check({tag, ".flags"}, g_fl(k), {61'd0, e_fl});
`ifdef COLLATZ_PEAK_EN
      check({tag, ".out1"}, g_o1(k), 64'(e_peak));
`endif
      got_o0  = g_o0(k);
      got_fl  = g_fl(k);
      got_lat = lat;
      held    = g_o0(k);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, {63'd0, ov[k]}, 64'd1);
         check({tag, ".hold_ready"}, {63'd0, ir[k]}, 64'd0);
         check({tag, ".hold_out0"}, g_o0(k), held);
      end
      orr[k] = 1'b1;
      @(posedge clk); #1;
      orr[k] = 1'b0;
      check({tag, ".idle_valid"}, {63'd0, ov[k]}, 64'd0);
      check({tag, ".idle_ready"}, {63'd0, ir[k]}, 64'd1);
      check({tag, ".idle_out0"}, g_o0(k), held);
   endtask

   initial begin
      logic [63:0] r_o0, r_fl;
      int          r_lat;
      int          seen;
      nrst  = 1'b0;
      iv    = '0;
      orr   = '0;
      in0_v = '0;
      #3;
      for (int k = 0; k < 3; k++) begin
         check("rst.in_ready", {63'd0, ir[k]}, 64'd1);
         check("rst.out_valid", {63'd0, ov[k]}, 64'd0);
         check("rst.out0", g_o0(k), 64'd0);
         check("rst.flags", g_fl(k), 64'd0);
      end
      @(negedge clk);
      nrst = 1'b1;

      run(0, 27, 27, 16, 5, "d27", r_o0, r_fl, r_lat);
      check("d27.const_out0", r_o0, 64'd111);
      check("d27.const_lat", 64'(r_lat), 64'd112);
      check("d27.const_flags", r_fl, 64'd0);
`ifdef COLLATZ_PEAK_EN
      check("d27.const_peak", g_o1(0), 64'd9232);
`endif
      run(0, 1, 27, 16, 0, "d1", r_o0, r_fl, r_lat);
      check("d1.const_lat", 64'(r_lat), 64'd1);
      check("d1.const_out0", r_o0, 64'd0);
      run(0, 6, 27, 16, 1, "d6", r_o0, r_fl, r_lat);
      check("d6.const_out0", r_o0, 64'd8);
      run(0, 0, 27, 16, 0, "d0", r_o0, r_fl, r_lat);
      check("d0.const_flags", r_fl, 64'd1);
      check("d0.const_lat", 64'(r_lat), 64'd0);
      run(1, 27, 8, 16, 0, "w8_27", r_o0, r_fl, r_lat);
      check("w8_27.const_out0", r_o0, 64'd11);
      check("w8_27.const_flags", r_fl, 64'd2);
      run(2, 27, 27, 4, 0, "c4_27", r_o0, r_fl, r_lat);
      check("c4_27.const_out0", r_o0, 64'd15);
      check("c4_27.const_flags", r_fl, 64'd4);

      for (int i = 0; i < 8; i++)
         run(0, longint'($urandom_range(1, 100000)), 27, 16, $urandom_range(0, 2),
             "rnd_def", r_o0, r_fl, r_lat);
      for (int i = 0; i < 6; i++)
         run(1, longint'($urandom_range(0, 255)), 8, 16, $urandom_range(0, 2),
             "rnd_w8", r_o0, r_fl, r_lat);
      for (int i = 0; i < 6; i++)
         run(2, longint'($urandom_range(1, 300)), 27, 4, $urandom_range(0, 2),
             "rnd_c4", r_o0, r_fl, r_lat);

      // Reset in the middle of a run aborts it without producing a result.
      @(posedge clk); #1;
      in0_v = 27'd27;
      iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      nrst = 1'b0;
      #1;
      check("abort.in_ready", {63'd0, ir[0]}, 64'd1);
      check("abort.out_valid", {63'd0, ov[0]}, 64'd0);
      check("abort.out0", g_o0(0), 64'd0);
      check("abort.flags", g_fl(0), 64'd0);
      @(negedge clk);
      nrst = 1'b1;
      seen = 0;
      repeat (120) begin
         @(posedge clk); #1;
         if (ov[0]) seen++;
      end
      check("abort.no_result", 64'(seen), 64'd0);
      run(0, 6, 27, 16, 0, "after_abort", r_o0, r_fl, r_lat);
      check("after_abort.const_out0", r_o0, 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
